// File: rtl/clk_sel_ctrl.sv
// Clock-source select controller: round-robin arbitration of switch requests,
// mux handshake, settle and dwell timing. Define CLK_SEL_CTRL_TIMEOUT_EN to abort stuck switches.
module clk_sel_ctrl #(
    parameter int SETTLE_CYC  = 8,
    parameter int DWELL_CYC   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [2:0] i_req_valid,
    input  logic [5:0] i_req_src,
    output logic [2:0] o_req_ready,
    input  logic [2:0] i_mux_en,
    output logic [1:0] o_sel_clk,
    output logic [1:0] o_cur_src,
    output logic       o_busy,
    output logic       o_err,
    input  logic       i_err_clr
);

    localparam int MAX_SD  = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int MAX_CYC = (MAX_SD > TIMEOUT_CYC) ? MAX_SD : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DWELL_END  = CW'(DWELL_CYC - 1);
`ifdef CLK_SEL_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] TO_END     = CW'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_SWITCH, S_SETTLE, S_DWELL} state_t;

    state_t          r_state;
    logic [2:0]      r_en_m, r_en_s;
    logic [1:0]      r_rr, r_tgt, r_sel_clk, r_cur_src;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    logic [1:0]      w_gnt_idx, w_tgt, w_rr_next;
    logic            w_gnt_any, w_en_hit;
    logic [CW-1:0]   w_cnt_inc;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
        int j;
        j = int'(base) + k;
        return 2'((j >= 3) ? j - 3 : j);
    endfunction

    // Scan from highest to lowest offset so the requester nearest rr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (i_req_valid[rr_idx(r_rr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = rr_idx(r_rr, k);
            end
        end
    end

    assign w_tgt     = i_req_src[{w_gnt_idx, 1'b0} +: 2];
    assign w_rr_next = (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
    assign w_en_hit  = (r_en_s == (3'b001 << r_tgt));
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

    // Accept pulse is combinational in ARB so a withdrawn request never sees it.
    assign o_req_ready = (r_state == S_ARB && w_gnt_any) ? (3'b001 << w_gnt_idx) : 3'b000;
    assign o_busy      = (r_state != S_IDLE);
    assign o_sel_clk   = r_sel_clk;
    assign o_cur_src   = r_cur_src;
    assign o_err       = r_err;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_en_m <= 3'b001;
            r_en_s <= 3'b001;
        end else begin
            r_en_m <= i_mux_en;
            r_en_s <= r_en_m;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr      <= 2'd0;
            r_tgt     <= 2'd0;
            r_sel_clk <= 2'd0;
            r_cur_src <= 2'd0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            // Any set below is a later assignment, so set beats clear.
            if (i_err_clr) r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (|i_req_valid) r_state <= S_ARB;
                S_ARB: begin
                    r_state <= S_IDLE;
                    if (w_gnt_any) begin
                        r_rr <= w_rr_next;
                        if (w_tgt == 2'd3) begin
                            r_err <= 1'b1;
                        end else if (w_tgt != r_cur_src) begin
                            r_tgt     <= w_tgt;
                            r_sel_clk <= w_tgt;
                            r_cnt     <= '0;
                            r_state   <= S_SWITCH;
                        end
                    end
                end
                S_SWITCH: begin
                    if (w_en_hit) begin
                        r_cnt   <= '0;
                        r_state <= S_SETTLE;
                    end
`ifdef CLK_SEL_CTRL_TIMEOUT_EN
                    else if (r_cnt == TO_END) begin
                        r_err     <= 1'b1;
                        r_sel_clk <= r_cur_src;
                        r_cnt     <= '0;
                        r_state   <= S_DWELL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_END) begin
                        r_cur_src <= r_tgt;
                        r_cnt     <= '0;
                        r_state   <= S_DWELL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DWELL: begin
                    if (r_cnt == DWELL_END) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
